nn_layer_sequencer: RTL and testbench

- FSM controller that drives the two-layer neuron datapath through one full inference for a single image.
- Walks layer 0 (4 groups × 8 input levels), then layer 1 (2 groups × 4 levels). Handshakes with the neuron array (start/finish).
- Loads hidden registers after each layer-0 group and answer registers after each layer-1 group.
- Sits between the top-level user interface (start/index/done) and the datapath select/load inputs.

---
 rtl/nn_seq_pkg.sv | 23 ++
 rtl/nn_seq_counter.sv | 45 ++++
 rtl/nn_layer_sequencer.sv | 135 +++++++++++++
 tb/tb_nn_layer_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_seq_pkg.sv
// Shared types and geometry for the two-layer inference sequencer.
// Optional perf counters in nn_layer_sequencer are enabled by NN_SEQ_PERF_CNT_EN.
package nn_seq_pkg;

  localparam int unsigned L0_GROUPS = 4;
  localparam int unsigned L0_LEVELS = 8;
  localparam int unsigned L1_GROUPS = 2;
  localparam int unsigned L1_LEVELS = 4;
  localparam int unsigned GP_W      = 2;
  localparam int unsigned LVL_W     = 3;
  localparam int unsigned IDX_W     = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_LOAD,
    S_DONE
  } state_t;

endpackage

// File: rtl/nn_seq_counter.sv
// Nested level -> group -> layer position counter with end-of-range flags.
module nn_seq_counter
  import nn_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             step_level,
  input  logic             step_group,
  output logic [GP_W-1:0]  gp,
  output logic             layer,
  output logic [LVL_W-1:0] level,
  output logic             last_level,
  output logic             last_group,
  output logic             last_layer
);

  // A group step rolls level to 0 and, past the last layer-0 group, moves to layer 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gp    <= '0;
      layer <= 1'b0;
      level <= '0;
    end else if (clear) begin
      gp    <= '0;
      layer <= 1'b0;
      level <= '0;
    end else if (step_group) begin
      level <= '0;
      if (last_group) begin
        gp    <= '0;
        layer <= 1'b1;
      end else begin
        gp <= gp + GP_W'(1);
      end
    end else if (step_level) begin
      level <= level + LVL_W'(1);
    end
  end

  assign last_level = layer ? (level == LVL_W'(L1_LEVELS - 1)) : (level == LVL_W'(L0_LEVELS - 1));
  assign last_group = layer ? (gp == GP_W'(L1_GROUPS - 1)) : (gp == GP_W'(L0_GROUPS - 1));
  assign last_layer = layer;

endmodule

// File: rtl/nn_layer_sequencer.sv
// Drives the neuron datapath through one two-layer inference per accepted start.
// Define NN_SEQ_PERF_CNT_EN to add the cycle_cnt / stall_cnt performance outputs.
module nn_layer_sequencer
  import nn_seq_pkg::*;
#(
  parameter int unsigned IDX_BITS = IDX_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [IDX_BITS-1:0] img_index,
  input  logic                nrn_finish,
  output logic                nrn_start,
  output logic                nrn_rst,
  output logic [GP_W-1:0]     gp,
  output logic                layer,
  output logic [LVL_W-1:0]    level,
  output logic [3:0]          ld,
  output logic [1:0]          ld_ans,
  output logic [IDX_BITS-1:0] index,
  output logic                busy,
  output logic                done
`ifdef NN_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]         cycle_cnt,
  output logic [15:0]         stall_cnt
`endif
);

  state_t state;
  logic   clear;
  logic   step_level;
  logic   step_group;
  logic   last_level;
  logic   last_group;
  logic   last_layer;

  assign clear      = (state == S_IDLE) && start;
  assign step_level = (state == S_WAIT) && nrn_finish && !last_level;
  assign step_group = (state == S_LOAD) && !(last_group && last_layer);

  nn_seq_counter u_counter (
    .clk        (clk),
    .rst_n      (rst),
    .clear      (clear),
    .step_level (step_level),
    .step_group (step_group),
    .gp         (gp),
    .layer      (layer),
    .level      (level),
    .last_level (last_level),
    .last_group (last_group),
    .last_layer (last_layer)
  );

  // Pulse outputs are set on the edge entering their state, so each lasts exactly that state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      nrn_start <= 1'b0;
      nrn_rst   <= 1'b0;
      ld        <= '0;
      ld_ans    <= '0;
      index     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      nrn_start <= 1'b0;
      nrn_rst   <= 1'b0;
      ld        <= '0;
      ld_ans    <= '0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            index   <= img_index;
            busy    <= 1'b1;
            nrn_rst <= 1'b1;
            state   <= S_CLR;
          end
        end
        S_CLR:   state <= S_FETCH;
        S_FETCH: begin
          nrn_start <= 1'b1;
          state     <= S_ISSUE;
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (nrn_finish) begin
            if (last_level) begin
              if (layer) ld_ans <= 2'(2'd1 << gp[0]);
              else       ld     <= 4'(4'd1 << gp);
              state <= S_LOAD;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_LOAD: begin
          if (last_group && last_layer) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            nrn_rst <= 1'b1;
            state   <= S_CLR;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef NN_SEQ_PERF_CNT_EN
  // Cycle count covers CLR through the final LOAD; both counters hold once idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
    end else if (clear) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (busy && (state != S_DONE) && (cycle_cnt != 16'hFFFF))
        cycle_cnt <= cycle_cnt + 16'd1;
      if ((state == S_WAIT) && !nrn_finish && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Scoreboard bench for nn_layer_sequencer: expected events queued per run, checked by a monitor.
module tb_nn_layer_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] img_index;
  logic       nrn_finish;
  logic       nrn_start, nrn_rst, layer, busy, done;
  logic [1:0] gp;
  logic [2:0] level;
  logic [3:0] ld;
  logic [1:0] ld_ans;
  logic [9:0] index;
`ifdef NN_SEQ_PERF_CNT_EN
  logic [15:0] cycle_cnt, stall_cnt;
`endif

  nn_layer_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .img_index  (img_index),
    .nrn_finish (nrn_finish),
    .nrn_start  (nrn_start),
    .nrn_rst    (nrn_rst),
    .gp         (gp),
    .layer      (layer),
    .level      (level),
    .ld         (ld),
    .ld_ans     (ld_ans),
    .index      (index),
    .busy       (busy),
    .done       (done)
`ifdef NN_SEQ_PERF_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;   // 0 nrn_start, 1 ld, 2 ld_ans, 3 done
    int lyr;
    int grp;
    int lvl;
    int idx;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  start_cyc = 0;
  int  exp_lat = 0;
  int  f_cyc = 1;
  bit  hold_fin = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint out_vec();
    return longint'({nrn_start, nrn_rst, gp, layer, level, ld, ld_ans, busy, done, index});
  endfunction

  // Neuron array model: finish on the f_cyc-th WAIT cycle, or hold finish high.
  initial begin
    nrn_finish = 1'b0;
    forever begin
      @(negedge clk);
      if (hold_fin) nrn_finish = 1'b1;
      else begin
        nrn_finish = 1'b0;
        if (nrn_start) begin
          repeat (f_cyc) @(negedge clk);
          nrn_finish = 1'b1;
          @(negedge clk);
          nrn_finish = 1'b0;
        end
      end
    end
  end

  // Monitor: pop and compare each time the DUT emits an event.
  ev_t e_m;
  int  kind_m;
  always @(negedge clk) begin
    if (rst) begin
      kind_m = -1;
      if (nrn_start)        kind_m = 0;
      else if (ld != 0)     kind_m = 1;
      else if (ld_ans != 0) kind_m = 2;
      else if (done)        kind_m = 3;
      if (kind_m >= 0) begin
        if (q.size() == 0) check("unexpected_event", kind_m, -1);
        else begin
          e_m = q.pop_front();
          check("event_kind", kind_m, e_m.kind);
          case (e_m.kind)
            0: begin
              check("layer", layer, e_m.lyr);
              check("gp", gp, e_m.grp);
              check("level", level, e_m.lvl);
              check("index", index, e_m.idx);
            end
            1: check("ld", ld, e_m.grp == 0 ? 1 : e_m.grp == 1 ? 2 : e_m.grp == 2 ? 4 : 8);
            2: check("ld_ans", ld_ans, e_m.grp == 0 ? 1 : 2);
            default: begin
              check("done_latency", cyc - start_cyc, exp_lat);
              check("busy_at_done", busy, 1);
            end
          endcase
        end
      end
    end
  end

  task automatic push_run(input int idx);
    for (int g = 0; g < 4; g++) begin
      for (int l = 0; l < 8; l++) q.push_back('{0, 0, g, l, idx});
      q.push_back('{1, 0, g, 0, idx});
    end
    for (int g = 0; g < 2; g++) begin
      for (int l = 0; l < 4; l++) q.push_back('{0, 1, g, l, idx});
      q.push_back('{2, 1, g, 0, idx});
    end
    q.push_back('{3, 1, 1, 3, idx});
  endtask

  task automatic do_start(input int idx, input int lat);
    exp_lat = lat;
    push_run(idx);
    @(negedge clk);
    start = 1'b1;
    img_index = 10'(idx);
    @(posedge clk);
    #1 start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    img_index = '0;
    check("index_latched", index, idx);
    check("busy_after_start", busy, 1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 1000 && q.size() != 0; i++) @(posedge clk);
    check(name, q.size(), 0);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("done_single_cycle", done, 0);
  endtask

  int found;

  initial begin
    rst = 1'b0;
    start = 1'b0;
    img_index = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outputs", out_vec(), 0);

    // Nominal F=1 run with an ignored start while busy.
    f_cyc = 1;
    do_start(37, 132);
    repeat (19) @(negedge clk);
    start = 1'b1;
    img_index = 10'd99;
    @(negedge clk);
    start = 1'b0;
    img_index = '0;
    @(negedge clk);
    check("index_hold_busy_start", index, 37);
    drain("nominal_drain");

    // Slow neurons, new start accepted after done.
    f_cyc = 5;
    repeat (3) @(negedge clk);
    do_start(512, 292);
    drain("slow_drain");

    // Finish held high throughout.
    hold_fin = 1'b1;
    repeat (3) @(negedge clk);
    do_start(3, 132);
    drain("spurious_drain");
    hold_fin = 1'b0;

    // Mid-run reset in a layer-1 WAIT.
    f_cyc = 5;
    repeat (3) @(negedge clk);
    do_start(37, 292);
    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      @(negedge clk);
      #1 if (nrn_start && layer) found = 1;
    end
    check("reach_layer1", found, 1);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    #1 check("abort_outputs", out_vec(), 0);
    repeat (5) @(negedge clk);
    check("abort_held", out_vec(), 0);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    check("post_abort_idle", out_vec(), 0);

    f_cyc = 1;
    do_start(37, 132);
    drain("clean_rerun_drain");

`ifdef NN_SEQ_PERF_CNT_EN
    f_cyc = 3;
    repeat (3) @(negedge clk);
    do_start(1, 212);
    drain("perf_drain");
    check("cycle_cnt", cycle_cnt, 212);
    check("stall_cnt", stall_cnt, 80);
    repeat (5) @(negedge clk);
    check("cycle_cnt_hold", cycle_cnt, 212);
    check("stall_cnt_hold", stall_cnt, 80);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
